// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: raster-order display prefetch FIFO
// with all spare RAM cycles handed to a drawing client.
module vga_fb_arbiter #(
    parameter int H_VISIBLE_AREA = 800,
    parameter int V_VISIBLE_AREA = 600,
    parameter int ADDR_WIDTH     = 19,
    parameter int DATA_WIDTH     = 12,
    parameter int FIFO_DEPTH     = 16,
    parameter int LOW_WATER      = 4
) (
    input  logic                  VGA_CLK,
    input  logic                  RESET_N,
    input  logic                  frame_start,
    input  logic                  pix_req,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  underflow,
    input  logic                  draw_req,
    input  logic                  draw_we,
    input  logic [ADDR_WIDTH-1:0] draw_addr,
    input  logic [DATA_WIDTH-1:0] draw_wdata,
    output logic                  draw_gnt,
    output logic [DATA_WIDTH-1:0] draw_rdata,
    output logic                  draw_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH:0] TOTAL =
        (ADDR_WIDTH+1)'(H_VISIBLE_AREA * V_VISIBLE_AREA);
    localparam logic [CW-1:0] LW_C    = CW'(LOW_WATER);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     ptr_q, ptr_d, ptr_eff;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_eff;
    logic [PW-1:0]           rd_q, rd_d, rd_eff;
    logic [PW-1:0]           wr_q, wr_d, wr_eff;
    logic [CW-1:0]           infl, level;
    logic                    dtag1_q, dtag2_q;
    logic                    rtag1_q, rtag2_q;
    logic                    mem_en_q, mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]   pix_data_q, pix_data_d;
    logic                    underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
    logic                    fetch_on, can_fetch, urgent;
    logic                    disp_sel, gnt, push, pop;
    logic [DATA_WIDTH-1:0]   pop_data;

    // Arbitration, FIFO bookkeeping and next-state; frame_start acts in its own cycle
    always_comb begin
        fetch_on  = frame_start || (state_q == S_FETCH);
        ptr_eff   = frame_start ? '0 : ptr_q;
        cnt_eff   = frame_start ? '0 : cnt_q;
        rd_eff    = frame_start ? '0 : rd_q;
        wr_eff    = frame_start ? '0 : wr_q;
        infl      = frame_start ? '0 : (CW'(dtag1_q) + CW'(dtag2_q));
        level     = cnt_eff + infl;
        can_fetch = fetch_on && (ptr_eff < TOTAL);
        urgent    = can_fetch && (level < LW_C);
        disp_sel  = urgent ||
                    (can_fetch && !draw_req && (level < DEPTH_C));
        gnt       = RESET_N && draw_req && !urgent;
        push      = dtag2_q && !frame_start;
        pop       = pix_req && ((cnt_eff != '0) || push);
        pop_data  = (cnt_eff == '0) ? mem_rdata : fifo_q[rd_eff];

        ptr_d = ptr_eff + (ADDR_WIDTH+1)'(disp_sel);
        cnt_d = cnt_eff + CW'(push) - CW'(pop);
        wr_d  = wr_eff + PW'(push);
        rd_d  = rd_eff + PW'(pop);

        state_d = state_q;
        if (frame_start) begin
            state_d = S_FETCH;
        end else if (state_q == S_FETCH && ptr_d == TOTAL) begin
            state_d = S_DONE;
        end

        mem_addr_d = '0;
        if (disp_sel) begin
            mem_addr_d = ptr_eff[ADDR_WIDTH-1:0];
        end else if (gnt) begin
            mem_addr_d = draw_addr;
        end
        mem_wdata_d = (gnt && draw_we) ? draw_wdata : '0;

        pix_data_d  = pix_data_q;
        underflow_d = underflow_q;
        if (pix_req) begin
            if (pop) begin
                pix_data_d = pop_data;
            end else begin
                pix_data_d  = '0;
                underflow_d = 1'b1;
            end
        end
    end

    // Control state, RAM command registers and read-tag pipeline
    always_ff @(posedge VGA_CLK) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            dtag1_q     <= 1'b0;
            dtag2_q     <= 1'b0;
            rtag1_q     <= 1'b0;
            rtag2_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pix_data_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            dtag1_q     <= disp_sel;
            dtag2_q     <= dtag1_q && !frame_start;
            rtag1_q     <= gnt && !draw_we;
            rtag2_q     <= rtag1_q;
            mem_en_q    <= disp_sel || gnt;
            mem_we_q    <= gnt && draw_we;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pix_data_q  <= pix_data_d;
            underflow_q <= underflow_d;
        end
    end

    // Display FIFO storage; returning prefetch data lands at the write pointer
    always_ff @(posedge VGA_CLK) begin
        if (push) begin
            fifo_q[wr_eff] <= mem_rdata;
        end
    end

    assign pix_data    = pix_data_q;
    assign underflow   = underflow_q;
    assign draw_gnt    = gnt;
    assign draw_rvalid = rtag2_q;
    assign draw_rdata  = rtag2_q ? mem_rdata : '0;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with an 8x4 frame,
// 8-deep FIFO and a one-cycle-latency RAM model.
module tb_vga_fb_arbiter;

    localparam int AW = 5;
    localparam int DW = 12;

    logic          VGA_CLK = 1'b0;
    logic          RESET_N;
    logic          frame_start;
    logic          pix_req;
    logic [DW-1:0] pix_data;
    logic          underflow;
    logic          draw_req;
    logic          draw_we;
    logic [AW-1:0] draw_addr;
    logic [DW-1:0] draw_wdata;
    logic          draw_gnt;
    logic [DW-1:0] draw_rdata;
    logic          draw_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram [32];
    logic [DW-1:0] exp_ram [32];
    logic          ram_ok = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;

    vga_fb_arbiter #(
        .H_VISIBLE_AREA(8),
        .V_VISIBLE_AREA(4),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(8),
        .LOW_WATER(3)
    ) dut (
        .VGA_CLK(VGA_CLK),
        .RESET_N(RESET_N),
        .frame_start(frame_start),
        .pix_req(pix_req),
        .pix_data(pix_data),
        .underflow(underflow),
        .draw_req(draw_req),
        .draw_we(draw_we),
        .draw_addr(draw_addr),
        .draw_wdata(draw_wdata),
        .draw_gnt(draw_gnt),
        .draw_rdata(draw_rdata),
        .draw_rvalid(draw_rvalid),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    // Single-port RAM: read data valid the cycle after the enable
    always @(posedge VGA_CLK) begin
        if (!ram_ok) begin
            for (int i = 0; i < 32; i++) ram[i] <= DW'(12'h100 + 17 * i);
            ram_ok <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic pop_frame(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            pix_req = 1'b1;
            tick();
            chk($sformatf("%s_pix%0d", tag, i), 32'(pix_data),
                32'(exp_ram[i]));
        end
        pix_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_ram[i] = DW'(12'h100 + 17 * i);
        RESET_N     = 1'b0;
        frame_start = 1'b0;
        pix_req     = 1'b0;
        draw_req    = 1'b1;
        draw_we     = 1'b0;
        draw_addr   = '0;
        draw_wdata  = '0;
        repeat (4) tick();

        chk("rst_gnt", 32'(draw_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_pix", 32'(pix_data), 0);
        chk("rst_uflow", 32'(underflow), 0);
        chk("rst_rvalid", 32'(draw_rvalid), 0);
        draw_req = 1'b0;
        RESET_N  = 1'b1;
        tick();
        chk("idle_mem_en", 32'(mem_en), 0);

        // T1: frame prefetch fills the FIFO then stops
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t1_en%0d", k), 32'(mem_en), 1);
            chk($sformatf("t1_we%0d", k), 32'(mem_we), 0);
            chk($sformatf("t1_addr%0d", k), 32'(mem_addr), k);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_quiet%0d", k), 32'(mem_en), 0);
            tick();
        end

        // T2: draw write with FIFO full
        draw_req   = 1'b1;
        draw_we    = 1'b1;
        draw_addr  = 5'd5;
        draw_wdata = 12'hABC;
        #1;
        chk("t2_gnt", 32'(draw_gnt), 1);
        tick();
        draw_req = 1'b0;
        chk("t2_en", 32'(mem_en), 1);
        chk("t2_we", 32'(mem_we), 1);
        chk("t2_addr", 32'(mem_addr), 5);
        chk("t2_wdata", 32'(mem_wdata), 32'hABC);

        draw_req = 1'b1;
        draw_we  = 1'b0;
        #1;
        chk("t2_rd_gnt", 32'(draw_gnt), 1);
        tick();
        draw_req = 1'b0;
        chk("t2_rv_n1", 32'(draw_rvalid), 0);
        tick();
        chk("t2_rv_n2", 32'(draw_rvalid), 1);
        chk("t2_rdata", 32'(draw_rdata), 32'hABC);
        tick();
        chk("t2_rv_n3", 32'(draw_rvalid), 0);

        // Prefetched words predate the write to address 5
        pop_frame("t2", 8);
        chk("t2_uflow", 32'(underflow), 0);
        exp_ram[5] = 12'hABC;

        // T3: display fetch beats draw while level < 3
        frame_start = 1'b1;
        draw_req    = 1'b1;
        draw_we     = 1'b0;
        draw_addr   = '0;
        #1;
        chk("t3_gnt_c0", 32'(draw_gnt), 0);
        tick();
        frame_start = 1'b0;
        #1;
        chk("t3_gnt_c1", 32'(draw_gnt), 0);
        tick();
        chk("t3_gnt_c2", 32'(draw_gnt), 0);
        tick();
        chk("t3_gnt_c3", 32'(draw_gnt), 1);
        repeat (7) tick();

        // T4: continuous scan-out with draw always requesting
        pop_frame("t4", 32);
        chk("t4_uflow", 32'(underflow), 0);
        draw_req = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_done%0d", k), 32'(mem_en), 0);
            tick();
        end

        // T5: pop on empty FIFO
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
        chk("t5_uflow", 32'(underflow), 1);
        chk("t5_pix0", 32'(pix_data), 0);
        draw_req   = 1'b1;
        draw_we    = 1'b1;
        draw_addr  = 5'd7;
        draw_wdata = 12'h123;
        tick();
        draw_we = 1'b0;
        exp_ram[7] = 12'h123;
        #1;
        chk("t5_rd_gnt", 32'(draw_gnt), 1);
        tick();
        draw_req = 1'b0;
        tick();
        chk("t5_rv", 32'(draw_rvalid), 1);
        chk("t5_rdata", 32'(draw_rdata), 32'h123);
        chk("t5_sticky", 32'(underflow), 1);

        // T6: restart frame with two display reads in flight
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (12) tick();
        pop_frame("t6", 8);
        chk("t6_sticky", 32'(underflow), 1);

        // Reset with a draw read outstanding drops the result
        draw_req  = 1'b1;
        draw_addr = 5'd3;
        #1;
        chk("rst2_gnt", 32'(draw_gnt), 1);
        tick();
        draw_req = 1'b0;
        RESET_N  = 1'b0;
        tick();
        chk("rst2_rv_a", 32'(draw_rvalid), 0);
        tick();
        chk("rst2_rv_b", 32'(draw_rvalid), 0);
        chk("rst2_uflow", 32'(underflow), 0);
        chk("rst2_en", 32'(mem_en), 0);
        chk("rst2_pix", 32'(pix_data), 0);
        RESET_N = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
